lsu_mem_ctrl: RTL
=================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum ACCESS cycles before abort (0 disables timeout).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  datapath load/store request.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I load/store funct3.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port mem_read / mem_write  output  1 each  memory strobes.
REQ-011 SHALL have port mem_address  output  32  word-aligned address, bits [1:0] = 0.
REQ-012 SHALL have port mem_byte_enable  output  4  store byte lanes.
REQ-013 SHALL have port mem_wdata  output  32  lane-shifted store data.
REQ-014 SHALL have port mem_rdata  input  32  and mem_resp  input  1  memory read data and completion.
REQ-015 SHALL have port rsp_valid  output  1,  rsp_rdata  output  32,  rsp_err  output  1  completion pulse, formatted load data, error flag.

Function
REQ-016 SHALL implement FSM IDLE, ACCESS, DONE; req_ready = 1 only in IDLE.
REQ-017 In IDLE, req_valid SHALL capture we/funct3/addr/wdata and move to ACCESS (or DONE if error, REQ-023) next edge.
REQ-018 In ACCESS, mem_read (load) or mem_write (store) SHALL be held high, all mem_* outputs registered and stable, until mem_resp.
REQ-019 mem_resp in ACCESS SHALL latch formatted data and go to DONE; mem_resp outside ACCESS SHALL be ignored.
REQ-020 DONE SHALL assert rsp_valid for exactly one cycle, then return to IDLE; minimum latency = accept edge + 1 + memory wait + 1.
REQ-021 Store lanes: sb → 4'b0001 << addr[1:0], wdata byte replicated ×4; sh → 4'b0011 << addr[1:0], halfword replicated ×2; sw → 4'b1111.
REQ-022 Load format: lb/lh sign-extend, lbu/lhu zero-extend the byte/halfword at addr[1:0]; lw passes through; rsp_rdata = 0 for stores.
REQ-023 Illegal funct3 (load 011/110/111, store ≥011) SHALL skip ACCESS, go to DONE with rsp_err = 1.
REQ-024 If TIMEOUT_CYCLES ≠ 0 and ACCESS lasts TIMEOUT_CYCLES cycles without mem_resp, strobes SHALL drop and DONE SHALL report rsp_err = 1.
REQ-025 rsp_err SHALL be 0 on every normal completion.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, mem_read = mem_write = 0, rsp_valid = rsp_err = 0, rsp_rdata = 0, mem_address = 0, mem_byte_enable = 0, mem_wdata = 0, timeout counter = 0.
REQ-027 Reset mid-ACCESS SHALL abandon the access with no rsp_valid; first request after release accepted normally.

Configuration
REQ-028 With LSU_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] ≠ 0, SHALL skip ACCESS and report rsp_err = 1.
REQ-029 Without LSU_MISALIGN_TRAP_EN: offending low address bits SHALL be cleared (halfword → addr[0] = 0; word → addr[1:0] = 0) and the access SHALL proceed without error.

Structure
REQ-030 Load/store funct3 enums and the lsu_state_t enum SHALL live in the shared rv32i types package.
REQ-031 Load extraction/extension SHALL be a combinational sub-module lsu_load_align (inputs: rdata, funct3, offset; output: 32-bit result).

Verification
REQ-032 lb addr 0x1003, mem_rdata 0x80FF_FF00 → mem_address 0x1000, rsp_rdata 0xFFFF_FF80, rsp_err 0.
REQ-033 sh addr 0x2002, wdata 0x0000_BEEF → mem_byte_enable 4'b1100, mem_wdata 0xBEEF_BEEF, mem_write held until mem_resp.
REQ-034 lw addr 0x3001 → with macro: no mem_read, rsp_err 1; without macro: mem_address 0x3000, rsp_err 0.
REQ-035 TIMEOUT_CYCLES = 4, load, mem_resp never asserted → mem_read high exactly 4 cycles, then rsp_valid = rsp_err = 1.
REQ-036 rst_n pulsed low during ACCESS → strobes drop asynchronously, no rsp_valid; next lhu addr 0x10, mem_rdata 0x8001_0000 → rsp_rdata 0x0000_0000.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared RV32I load/store types: funct3 encodings, controller state, size/alignment helpers.
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} lsu_state_t;

  typedef enum logic [2:0] {
    LoadLb  = 3'b000,
    LoadLh  = 3'b001,
    LoadLw  = 3'b010,
    LoadLbu = 3'b100,
    LoadLhu = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    StoreSb = 3'b000,
    StoreSh = 3'b001,
    StoreSw = 3'b010
  } store_funct3_e;

  // funct3[1:0] encodes access size for both loads and stores.
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {StoreSb, StoreSh, StoreSw};
    return funct3 inside {LoadLb, LoadLh, LoadLw, LoadLbu, LoadLhu};
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      SizeHalf: return offset[0];
      SizeWord: return |offset;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      SizeHalf: return {offset[1], 1'b0};
      SizeWord: return 2'b00;
      default:  return offset;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Datapath request/response and memory bus of the load/store controller.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // slave: the controller; master: datapath plus memory around it.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// Combinational load-data extraction and sign/zero extension (module lsu_load_align).
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LoadLb:  result = {{24{byte_sel[7]}}, byte_sel};
      LoadLh:  result = {{16{half_sel[15]}}, half_sel};
      LoadLbu: result = {24'd0, byte_sel};
      LoadLhu: result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store memory controller: IDLE -> ACCESS -> DONE with optional timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of clearing low bits.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t state_q, state_d;

  logic            accept, reject, resp_hit, tmo_hit;
  logic [1:0]      offset_in;
  logic [3:0]      be_in;
  logic [31:0]     wdata_in;
  logic [31:0]     load_result;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic            mem_read_q, mem_write_q;
  logic [31:0]     mem_address_q, mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [TmoW-1:0] tmo_q;

  assign accept   = (state_q == StIdle) && bus.req_valid;
  assign resp_hit = (state_q == StAccess) && bus.mem_resp;
  assign tmo_hit  = (state_q == StAccess) && !bus.mem_resp && (TIMEOUT_CYCLES != 0) &&
                    (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject    = !funct3_legal(bus.req_we, bus.req_funct3) ||
                     misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign offset_in = bus.req_addr[1:0];
`else
  assign reject    = !funct3_legal(bus.req_we, bus.req_funct3);
  assign offset_in = align_offset(bus.req_funct3, bus.req_addr[1:0]);
`endif

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = bus.req_wdata;
    case (bus.req_funct3[1:0])
      SizeByte: begin
        be_in    = 4'b0001 << offset_in;
        wdata_in = {4{bus.req_wdata[7:0]}};
      end
      SizeHalf: begin
        be_in    = 4'b0011 << offset_in;
        wdata_in = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata  (bus.mem_rdata),
    .funct3 (funct3_q),
    .offset (offset_q),
    .result (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = reject ? StDone : StAccess;
      StAccess: if (resp_hit || tmo_hit) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready       = (state_q == StIdle);
    bus.rsp_valid       = (state_q == StDone);
    bus.rsp_rdata       = rsp_rdata_q;
    bus.rsp_err         = rsp_err_q;
    bus.mem_read        = mem_read_q;
    bus.mem_write       = mem_write_q;
    bus.mem_address     = mem_address_q;
    bus.mem_byte_enable = mem_be_q;
    bus.mem_wdata       = mem_wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      offset_q      <= 2'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'd0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
      tmo_q         <= '0;
    end else if (accept) begin
      we_q        <= bus.req_we;
      funct3_q    <= bus.req_funct3;
      offset_q    <= offset_in;
      tmo_q       <= '0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= reject;
      if (!reject) begin
        mem_read_q    <= !bus.req_we;
        mem_write_q   <= bus.req_we;
        mem_address_q <= {bus.req_addr[31:2], 2'b00};
        mem_be_q      <= be_in;
        mem_wdata_q   <= wdata_in;
      end
    end else if (resp_hit) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_rdata_q <= we_q ? 32'd0 : load_result;
      rsp_err_q   <= 1'b0;
    end else if (tmo_hit) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_err_q   <= 1'b1;
    end else if (state_q == StAccess) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

endmodule
